cv32e40p_mult_tmr_voter: RTL and testbench
==========================================

// Module: cv32e40p_mult_tmr_voter
// PURPOSE
//  Consumer end of the triplicated multiplier: takes the three replica output sets (result/multicycle/
//  mulh_active/ready) and presents one voted set to the EX stage.
//  Tracks per-replica disagreement and masks a replica that fails persistently.
//  Flags an unrecoverable fault when no majority remains.
//  Voted outputs are combinational (zero added latency); fault tracking is sequential.
// PARAMETERS
//  FAULT_THRESH  4  consecutive checked mismatches of one replica before it is masked (>=1)
//  CNT_W         8  width of per-replica saturating total-error counters
// PORTS
//  clk              in   1      core clock
//  rst_n            in   1      asynchronous active-low reset
//  result_1..3      in   32     replica results
//  multicycle_1..3  in   1      replica multicycle flags
//  mulh_active_1..3 in   1      replica mulh_active flags
//  ready_1..3       in   1      replica ready flags
//  check_en_i       in   1      compare strobe: mult enable_i & ex_ready_i (outputs are architecturally consumed)
//  clear_i          in   1      synchronous clear of fault state and counters
//  result_o         out  32     voted result
//  multicycle_o     out  1      voted multicycle
//  mulh_active_o    out  1      voted mulh_active
//  ready_o          out  1      voted ready
//  fault_o          out  1      pulse: mismatch seen on a checked cycle (registered, 1 cycle after)
//  masked_o         out  1      a replica is masked (state MASKED)
//  masked_id_o      out  2      masked replica 1..3; 0 when none
//  fatal_o          out  1      sticky: no trustworthy majority
//  err_cnt_1..3_o   out  CNT_W  saturating per-replica total mismatch counts
// BEHAVIOUR
//  - Vector Vk = {result_k, multicycle_k, mulh_active_k, ready_k} (35b).
//  - HEALTHY/SUSPECT: out = bitwise majority(V1,V2,V3).
//  - MASKED(k): out = lower-index non-masked replica.
//  - FATAL: out = lowest-index non-masked replica (replica 1 if none masked).
//  - Replica k mismatches when Vk != bitwise majority.
//  - Triple disagreement: all pairwise Vi != Vj.
//  - State only advances on cycles with check_en_i=1; otherwise all state/counters hold.
//  - States: HEALTHY, SUSPECT(k, run), MASKED(k), FATAL.
//    - HEALTHY: single mismatch of k -> SUSPECT(k, run=1); triple disagreement -> FATAL.
//    - SUSPECT: same k mismatches -> run+1; run reaching FAULT_THRESH -> MASKED(k).
//      No mismatch -> HEALTHY, run=0. Different single replica -> SUSPECT(new, run=1).
//      Triple disagreement -> FATAL.
//    - MASKED(k): two survivors compared; any difference -> FATAL. Masked replica is not compared or counted.
//    - FATAL: absorbing until clear_i or reset.
//  - FAULT_THRESH=1: first single mismatch goes HEALTHY -> MASKED directly.
//  - err_cnt_k +1 on each checked cycle where replica k mismatches; saturates at 2^CNT_W-1.
//    Triple disagreement increments all three counters.
//  - fault_o: registered, 1 the cycle after any checked mismatch (incl. masked-state divergence).
//  - clear_i=1: next state HEALTHY, counters 0, fatal_o/fault_o 0.
//    clear_i wins over a simultaneous check_en_i; no mismatch from that cycle is recorded.
//  - Reset (async, any time, incl. mid-SUSPECT): state HEALTHY, run 0, all counters 0,
//    fault_o=0, masked_o=0, masked_id_o=0, fatal_o=0.
//    Voted outputs reflect inputs combinationally (majority) during and after reset.
// TESTING
//  - Identical replicas 0x1234_5678, ready=1, check_en 100 cycles
//    -> result_o=0x1234_5678, fault_o never 1, all counters 0.
//  - result_2 bit 5 flipped for 3 checked cycles, FAULT_THRESH=4
//    -> result_o correct, err_cnt_2_o=3, fault_o pulses 3x, state back to HEALTHY when fixed, no mask.
//  - result_3 wrong 4 consecutive checked cycles -> masked_o=1, masked_id_o=3;
//    later result_3 garbage -> no fault_o, output follows replica 1.
//  - In MASKED(3), result_1=0xA, result_2=0xB on checked cycle
//    -> fatal_o=1 next cycle, sticky until clear_i; clear_i -> HEALTHY, counters 0.
//  - Replicas 0x1/0x2/0x4 on checked cycle -> FATAL, all counters=1;
//    same pattern with check_en_i=0 -> no state change.
//  - Force err_cnt_1 to 255 (CNT_W=8), 2 more mismatches -> stays 255.
//    Assert rst_n low mid-SUSPECT -> all flags/counters 0 immediately.

Source files
------------

// File: rtl/cv32e40p_mult_tmr_voter.sv
// Majority voter for the triplicated multiplier: combinational voted outputs plus
// sequential per-replica fault tracking, masking of a persistently failing replica, fatal flag.
module cv32e40p_mult_tmr_voter #(
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      result_1,
    input  logic [31:0]      result_2,
    input  logic [31:0]      result_3,
    input  logic             multicycle_1,
    input  logic             multicycle_2,
    input  logic             multicycle_3,
    input  logic             mulh_active_1,
    input  logic             mulh_active_2,
    input  logic             mulh_active_3,
    input  logic             ready_1,
    input  logic             ready_2,
    input  logic             ready_3,
    input  logic             check_en_i,
    input  logic             clear_i,
    output logic [31:0]      result_o,
    output logic             multicycle_o,
    output logic             mulh_active_o,
    output logic             ready_o,
    output logic             fault_o,
    output logic             masked_o,
    output logic [1:0]       masked_id_o,
    output logic             fatal_o,
    output logic [CNT_W-1:0] err_cnt_1_o,
    output logic [CNT_W-1:0] err_cnt_2_o,
    output logic [CNT_W-1:0] err_cnt_3_o
);
    localparam int unsigned      RUN_W  = $clog2(FAULT_THRESH + 1);
    localparam logic [RUN_W-1:0] THRESH = RUN_W'(FAULT_THRESH);

    typedef enum logic [1:0] {HEALTHY, SUSPECT, MASKED, FATAL} state_e;

    state_e                state_q, state_d;
    logic [1:0]            sus_id_q, sus_id_d, mask_id_q, mask_id_d;
    logic [RUN_W-1:0]      run_q, run_d, run_inc;
    logic                  fault_q, fault_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0][34:0]      vec;
    logic [34:0]           maj, surv_a, surv_b, voted;
    logic [2:0]            mm, inc, mask_oh;
    logic [1:0]            mm_id;
    logic                  triple, surv_diff, surv_mode;

    assign vec[0] = {result_1, multicycle_1, mulh_active_1, ready_1};
    assign vec[1] = {result_2, multicycle_2, mulh_active_2, ready_2};
    assign vec[2] = {result_3, multicycle_3, mulh_active_3, ready_3};

    assign maj    = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
    assign triple = (vec[0] != vec[1]) && (vec[0] != vec[2]) && (vec[1] != vec[2]);
    assign mm     = {vec[2] != maj, vec[1] != maj, vec[0] != maj};
    // Outside triple disagreement at most one replica can differ from the majority.
    assign mm_id  = mm[0] ? 2'd1 : (mm[1] ? 2'd2 : 2'd3);

    // surv_a is always the lowest-index replica not masked.
    always_comb begin
        surv_a  = vec[0];
        surv_b  = vec[1];
        mask_oh = 3'b000;
        case (mask_id_q)
            2'd1: begin surv_a = vec[1]; surv_b = vec[2]; mask_oh = 3'b001; end
            2'd2: begin surv_b = vec[2]; mask_oh = 3'b010; end
            2'd3: mask_oh = 3'b100;
            default: ;
        endcase
    end

    assign surv_diff = surv_a != surv_b;
    assign surv_mode = (state_q == MASKED) || (state_q == FATAL && mask_id_q != 2'd0);
    assign voted     = (state_q == HEALTHY || state_q == SUSPECT) ? maj : surv_a;
    assign inc       = surv_mode ? (surv_diff ? ~mask_oh : 3'b000)
                                 : (triple ? 3'b111 : mm);
    assign fault_d   = |inc;
    assign run_inc   = (state_q == SUSPECT && sus_id_q == mm_id) ? run_q + RUN_W'(1) : RUN_W'(1);

    always_comb begin
        state_d   = state_q;
        sus_id_d  = sus_id_q;
        run_d     = run_q;
        mask_id_d = mask_id_q;
        case (state_q)
            HEALTHY, SUSPECT: begin
                if (triple) begin
                    state_d = FATAL;
                    run_d   = '0;
                end else if (|mm) begin
                    if (run_inc >= THRESH) begin
                        state_d   = MASKED;
                        mask_id_d = mm_id;
                        run_d     = '0;
                    end else begin
                        state_d  = SUSPECT;
                        sus_id_d = mm_id;
                        run_d    = run_inc;
                    end
                end else begin
                    state_d = HEALTHY;
                    run_d   = '0;
                end
            end
            MASKED: if (surv_diff) state_d = FATAL;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < 3; k++)
            if (inc[k] && cnt_q[k] != {CNT_W{1'b1}}) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HEALTHY;
            sus_id_q  <= 2'd0;
            mask_id_q <= 2'd0;
            run_q     <= '0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (clear_i) begin
            state_q   <= HEALTHY;
            sus_id_q  <= 2'd0;
            mask_id_q <= 2'd0;
            run_q     <= '0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (check_en_i) begin
            state_q   <= state_d;
            sus_id_q  <= sus_id_d;
            mask_id_q <= mask_id_d;
            run_q     <= run_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end else begin
            fault_q   <= 1'b0;
        end
    end

    assign {result_o, multicycle_o, mulh_active_o, ready_o} = voted;
    assign fault_o     = fault_q;
    assign masked_o    = (state_q == MASKED);
    assign masked_id_o = masked_o ? mask_id_q : 2'd0;
    assign fatal_o     = (state_q == FATAL);
    assign err_cnt_1_o = cnt_q[0];
    assign err_cnt_2_o = cnt_q[1];
    assign err_cnt_3_o = cnt_q[2];

endmodule

// File: tb/tb_cv32e40p_mult_tmr_voter.sv
// Scoreboard bench for the TMR multiplier voter: stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_cv32e40p_mult_tmr_voter;
    localparam int X = -1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          fault, msk, mid, fatal, c1, c2, c3;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst_n;
    logic [31:0] r1, r2, r3;
    logic [2:0]  f1, f2, f3, ef;
    logic        chk_en, clr;
    logic [31:0] result_o;
    logic        multicycle_o, mulh_active_o, ready_o, fault_o, masked_o, fatal_o;
    logic [1:0]  masked_id_o;
    logic [7:0]  c1_o, c2_o, c3_o;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   item  = 0;

    always #5 clk = ~clk;

    cv32e40p_mult_tmr_voter #(.FAULT_THRESH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .result_1(r1), .result_2(r2), .result_3(r3),
        .multicycle_1(f1[2]), .multicycle_2(f2[2]), .multicycle_3(f3[2]),
        .mulh_active_1(f1[1]), .mulh_active_2(f2[1]), .mulh_active_3(f3[1]),
        .ready_1(f1[0]), .ready_2(f2[0]), .ready_3(f3[0]),
        .check_en_i(chk_en), .clear_i(clr),
        .result_o(result_o), .multicycle_o(multicycle_o), .mulh_active_o(mulh_active_o),
        .ready_o(ready_o), .fault_o(fault_o), .masked_o(masked_o), .masked_id_o(masked_id_o),
        .fatal_o(fatal_o), .err_cnt_1_o(c1_o), .err_cnt_2_o(c2_o), .err_cnt_3_o(c3_o)
    );

    task automatic cmp(input string n, input longint act, input longint exp);
        if (exp < 0) return;
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL item=%0d %s actual=0x%0h required=0x%0h", item, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("result", longint'(result_o), longint'(e.res));
            cmp("flags", longint'({multicycle_o, mulh_active_o, ready_o}), longint'(e.fl));
            cmp("fault", longint'(fault_o), e.fault);
            cmp("masked", longint'(masked_o), e.msk);
            cmp("masked_id", longint'(masked_id_o), e.mid);
            cmp("fatal", longint'(fatal_o), e.fatal);
            cmp("err_cnt_1", longint'(c1_o), e.c1);
            cmp("err_cnt_2", longint'(c2_o), e.c2);
            cmp("err_cnt_3", longint'(c3_o), e.c3);
            item++;
        end
    end

    function automatic exp_t mk(input logic [31:0] res, input int flt, input int m, input int id,
                                input int ft, input int a, input int b, input int c);
        exp_t e;
        e.res = res; e.fl = ef; e.fault = flt; e.msk = m; e.mid = id; e.fatal = ft;
        e.c1 = a; e.c2 = b; e.c3 = c;
        return e;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Registered expectations are the values visible during this step, i.e. before its edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic ce, input logic cl, input exp_t e);
        r1 = a; r2 = b; r3 = c; chk_en = ce; clr = cl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] A, B, C;

    initial begin
        A = 32'h1234_5678; B = A ^ 32'h20; C = 32'hDEAD_BEEF;
        f1 = 3'b001; f2 = 3'b001; f3 = 3'b001; ef = 3'b001;
        rst_n = 1'b0;
        // reset state, voted output already combinational
        step(A, A, C, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        repeat (100) step(A, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));

        // replica 2 bit 5 flipped for 3 checked cycles, then a single re-occurrence
        step(A, B, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        step(A, B, A, 1, 0, mk(A, 1, 0, 0, 0, 0, 1, 0));
        step(A, B, A, 1, 0, mk(A, 1, 0, 0, 0, 0, 2, 0));
        step(A, A, A, 1, 0, mk(A, 1, 0, 0, 0, 0, 3, 0));
        step(A, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 3, 0));
        step(A, B, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 3, 0));
        step(A, A, A, 1, 0, mk(A, 1, 0, 0, 0, 0, 4, 0));
        step(A, A, A, 1, 1, mk(A, 0, 0, 0, 0, 0, 4, 0));
        step(A, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));

        // replica 3 wrong 4 cycles -> masked
        step(A, A, C, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        step(A, A, C, 1, 0, mk(A, 1, 0, 0, 0, 0, 0, 1));
        step(A, A, C, 1, 0, mk(A, 1, 0, 0, 0, 0, 0, 2));
        step(A, A, C, 1, 0, mk(A, 1, 0, 0, 0, 0, 0, 3));
        step(A, A, 32'h0, 1, 0, mk(A, 1, 1, 3, 0, 0, 0, 4));
        step(A, A, 32'hFFFF_FFFF, 1, 0, mk(A, 0, 1, 3, 0, 0, 0, 4));
        step(32'h5, 32'h6, 32'h7, 0, 0, mk(32'h5, 0, 1, 3, 0, 0, 0, 4));
        // survivors diverge -> fatal, sticky until clear
        step(32'hA, 32'hB, C, 1, 0, mk(32'hA, 0, 1, 3, 0, 0, 0, 4));
        step(A, A, A, 1, 0, mk(A, 1, 0, 0, 1, X, X, 4));
        step(32'h5, 32'h6, 32'h7, 1, 0, mk(32'h5, X, 0, 0, 1, X, X, 4));
        step(A, A, A, 1, 1, mk(A, X, 0, 0, 1, X, X, 4));
        step(A, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));

        // triple disagreement
        step(32'h1, 32'h2, 32'h4, 1, 0, mk(32'h0, 0, 0, 0, 0, 0, 0, 0));
        step(32'h1, 32'h2, 32'h4, 0, 0, mk(32'h1, 1, 0, 0, 1, 1, 1, 1));
        step(32'h1, 32'h2, 32'h4, 0, 0, mk(32'h1, 0, 0, 0, 1, 1, 1, 1));
        step(A, A, A, 0, 1, mk(A, 0, 0, 0, 1, 1, 1, 1));
        step(32'h1, 32'h2, 32'h4, 0, 0, mk(32'h0, 0, 0, 0, 0, 0, 0, 0));
        step(32'h1, 32'h2, 32'h4, 0, 0, mk(32'h0, 0, 0, 0, 0, 0, 0, 0));
        step(A, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));

        // flag voting, unchecked
        f1 = 3'b111; f2 = 3'b001; f3 = 3'b000; ef = 3'b001;
        step(A, A, A, 0, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        f1 = 3'b110; f2 = 3'b110; f3 = 3'b001; ef = 3'b110;
        step(A, A, A, 0, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        f1 = 3'b001; f2 = 3'b001; f3 = 3'b001; ef = 3'b001;

        // alternate replica 1/2 faults so neither is masked; counters saturate
        for (int i = 0; i < 257; i++) begin
            step(B, A, A, 1, 0, mk(A, (i > 0) ? 1 : 0, 0, 0, 0, sat(i), sat(i), 0));
            step(A, B, A, 1, 0, mk(A, 1, 0, 0, 0, sat(i + 1), sat(i), 0));
        end
        step(B, A, A, 1, 0, mk(A, 1, 0, 0, 0, 255, 255, 0));
        rst_n = 1'b0;
        step(B, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(B, A, A, 1, 0, mk(A, 0, 0, 0, 0, 0, 0, 0));
        step(A, A, A, 1, 0, mk(A, 1, 0, 0, 0, 1, 0, 0));

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
